newton_sqrt_sched: RTL and testbench
====================================

NEWTON_SQRT_SCHED -- requirements
Module: newton_sqrt_sched

Parameters
REQ-001 The block SHALL have parameter LAT, default 25: cycles from the cycle sq_fsqrt is high to the cycle sq_q holds the final root.
REQ-002 The block SHALL have parameter CW, default 5: counter width, with LAT < 2**CW.

Interface
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  in  1  requester n has a sqrt operand.
REQ-006 req0_ready / req1_ready  out  1  operand accepted this cycle when valid is also high.
REQ-007 req0_d / req1_d  in  24  normalized mantissa; bit 23 is set.
REQ-008 req0_tag / req1_tag  in  5  destination FP register tag.
REQ-009 flush  in  1  cancel the in-flight or held result.
REQ-010 sq_fsqrt  out  1  start pulse to the sqrt unit.
REQ-011 sq_d  out  24  operand to the sqrt unit.
REQ-012 sq_en  out  1  output-pipeline enable to the sqrt unit.
REQ-013 sq_busy  in  1  sqrt unit busy flag; used only for checking.
REQ-014 sq_q  in  32  sqrt unit result.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer accepts the result.
REQ-017 res_q  out  32  held root.
REQ-018 res_tag  out  5  tag of the held root.
REQ-019 res_src  out  1  requester index of the held root.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT and HOLD.
REQ-022 Arbitration SHALL be round-robin on a 1-bit pointer last, and SHALL happen only in IDLE.
- Only one of req0, req1 valid: that one is granted.
- Both valid: the requester other than last is granted.
REQ-023 reqN_ready SHALL be combinational: high only in IDLE, for the granted requester, when flush is low; it is never high for both requesters.
REQ-024 On acceptance the block SHALL:
- register d into sq_d, and tag into the internal tag register;
- record the requester index in res_src;
- set last to the granted index;
- go to ISSUE.
REQ-025 ISSUE SHALL last exactly one cycle with sq_fsqrt=1, then go to WAIT.
- The latency counter loads 1 on entry to WAIT.
REQ-026 sq_d SHALL stay stable from ISSUE until the FSM next leaves WAIT, because the unit samples d one cycle after the start pulse.
REQ-027 sq_fsqrt SHALL be 0 in every state other than ISSUE.
REQ-028 sq_en SHALL be 1 in ISSUE and WAIT and 0 otherwise, so the unit's output pipeline freezes once the root is held.
REQ-029 In WAIT the counter SHALL increment each cycle.
- When counter == LAT-1, sq_q is captured into res_q.
- If the cancel flag is clear, the FSM goes to HOLD; if it is set, the FSM goes to IDLE and the flag clears.
REQ-030 Acceptance-to-res_valid latency SHALL be LAT+1 cycles.
REQ-031 res_valid SHALL equal (state==HOLD).
- In HOLD, res_ready=1 returns the FSM to IDLE on the next edge; the next acceptance can happen in the cycle after that.
REQ-032 res_q, res_tag and res_src SHALL hold stable throughout HOLD.
REQ-033 flush SHALL behave as follows:
- In WAIT or ISSUE: set the cancel flag; the running operation still completes, since the unit cannot abort, and its result is discarded.
- In HOLD: return to IDLE next cycle, even if res_ready is also high; no transfer counts.
- In IDLE: block acceptance that cycle.
REQ-034 A new request SHALL never start while a result is held or an operation is running (single outstanding operation).
REQ-035 The block SHALL NOT depend on sq_busy for sequencing.
- Simulation assertion: sq_busy must be 0 in the cycle sq_fsqrt is high.

Reset
REQ-036 While rst is high, on the clock edge the block SHALL set:
- state=IDLE, last=1 (so req0 wins the first tie), counter=0, cancel flag=0;
- sq_d=0, res_q=0, res_tag=0, res_src=0.
REQ-037 Reset mid-operation SHALL abandon the operation with no res_valid.
- Outputs during reset: res_valid=0, sq_fsqrt=0, sq_en=0, busy=0, both readys=0.

Verification
REQ-038 Single request: req0 with d=24'h800000 (1.0), tag 3, res_ready=1 -> res_valid exactly 26 cycles after acceptance, res_tag=3, res_src=0, res_q equal to the unit's root for that operand.
REQ-039 Tie: both valid from reset -> req0 served first, req1 second; repeating the tie alternates grants 0,1,0,1.
REQ-040 Backpressure: res_ready=0 for 10 cycles during HOLD -> res_q, res_tag and res_src hold stable, and no reqN_ready is asserted until one cycle after res_ready=1.
REQ-041 Flush in WAIT at counter=10 -> no res_valid; busy drops 25 cycles after ISSUE; the next request is accepted normally.
REQ-042 Flush in HOLD together with res_ready=1 -> IDLE next cycle; res_valid=0 the cycle after the flush.
REQ-043 Reset mid-operation: rst=1 at counter=12 -> all outputs at reset values next cycle; a fresh request completes with correct latency.

Source files
------------

// File: rtl/newton_sqrt_sched.sv
// Schedules square-root operations from two requesters onto a fixed-latency,
// non-abortable sqrt unit and holds each root until the consumer takes it.
module newton_sqrt_sched #(
    parameter int LAT = 25,
    parameter int CW  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [23:0] req0_d,
    input  logic [4:0]  req0_tag,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [23:0] req1_d,
    input  logic [4:0]  req1_tag,
    input  logic        flush,
    output logic        sq_fsqrt,
    output logic [23:0] sq_d,
    output logic        sq_en,
    input  logic        sq_busy,
    input  logic [31:0] sq_q,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_q,
    output logic [4:0]  res_tag,
    output logic        res_src,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_DONE = CW'(LAT - 1);

    state_t         state;
    state_t         state_next;
    logic           last;
    logic [CW-1:0]  cnt;
    logic           cancel;
    logic [4:0]     tag_reg;

    logic           any_valid;
    logic           grant;
    logic           can_accept;
    logic           accept;
    logic           done;

    // Round-robin: on a tie the requester that was not served last wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last;
        end else begin
            grant = req1_valid;
        end
    end

    assign can_accept = (state == IDLE) && !flush && !rst;
    assign req0_ready = can_accept && any_valid && !grant;
    assign req1_ready = can_accept && any_valid && grant;
    assign accept     = req0_ready | req1_ready;
    assign done       = (cnt == CNT_DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                // A flush arriving on the very last wait cycle still discards the root.
                if (done) begin
                    state_next = (cancel || flush) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (flush || res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        res_valid = 1'b0;
        sq_fsqrt  = 1'b0;
        sq_en     = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            res_valid = (state == HOLD);
            sq_fsqrt  = (state == ISSUE);
            sq_en     = (state == ISSUE) || (state == WAIT);
            busy      = (state != IDLE);
        end
    end

    assign res_tag = tag_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            cancel  <= 1'b0;
            sq_d    <= '0;
            res_q   <= '0;
            tag_reg <= '0;
            res_src <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sq_d    <= grant ? req1_d : req0_d;
                        tag_reg <= grant ? req1_tag : req0_tag;
                        res_src <= grant;
                        last    <= grant;
                    end
                end
                ISSUE: begin
                    cnt <= CW'(1);
                    if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (flush) begin
                        cancel <= 1'b1;
                    end
                    if (done) begin
                        res_q  <= sq_q;
                        cancel <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // The unit must be idle whenever a new operation is started.
    start_when_idle: assert property (@(posedge clk) disable iff (rst) sq_fsqrt |-> !sq_busy);
`endif

endmodule

// File: tb/tb_newton_sqrt_sched.sv
// Scoreboard bench for newton_sqrt_sched with a behavioural fixed-latency sqrt unit.
module tb_newton_sqrt_sched;

    localparam int LAT = 25;
    localparam int CW  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [23:0] req0_d, req1_d;
    logic [4:0]  req0_tag, req1_tag;
    logic        flush;
    logic        sq_fsqrt;
    logic [23:0] sq_d;
    logic        sq_en;
    logic        sq_busy;
    logic [31:0] sq_q;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_q;
    logic [4:0]  res_tag;
    logic        res_src;
    logic        busy;

    newton_sqrt_sched #(.LAT(LAT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_d(req0_d), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_d(req1_d), .req1_tag(req1_tag),
        .flush(flush),
        .sq_fsqrt(sq_fsqrt), .sq_d(sq_d), .sq_en(sq_en), .sq_busy(sq_busy), .sq_q(sq_q),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_tag(res_tag),
        .res_src(res_src), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Roots of perfect-square mantissas, Q1.31.
    function automatic logic [31:0] root_of(input logic [23:0] d);
        case (d)
            24'h800000: root_of = 32'h8000_0000;
            24'hA20000: root_of = 32'h9000_0000;
            24'hC80000: root_of = 32'hA000_0000;
            24'hF20000: root_of = 32'hB000_0000;
            default:    root_of = 32'hBAD0_0000;
        endcase
    endfunction

    // Sqrt unit: samples d one cycle after the start pulse, root valid LAT-1 cycles after it.
    int          ucnt;
    logic [23:0] d_s;
    always @(posedge clk) begin
        if (rst) begin
            ucnt    <= 0;
            sq_busy <= 1'b0;
            sq_q    <= '0;
        end else if (sq_fsqrt) begin
            ucnt    <= 1;
            sq_busy <= 1'b1;
            sq_q    <= 32'hDEAD_BEEF;
        end else if (ucnt != 0 && sq_en) begin
            ucnt <= ucnt + 1;
            if (ucnt == 1) d_s <= sq_d;
            if (ucnt == LAT - 2) sq_q <= root_of(d_s);
            if (ucnt == LAT - 1) begin
                ucnt    <= 0;
                sq_busy <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [31:0] q;
        logic [4:0]  tag;
        logic        src;
        int          at;
    } exp_t;

    exp_t sb[$];

    // Monitor: pop on each new result, then check the held result stays put.
    initial begin
        exp_t cur;
        bit in_hold;
        bit cur_ok;
        in_hold = 0;
        cur_ok  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_hold = 0;
            end else begin
                if (res_valid) begin
                    if (!in_hold) begin
                        in_hold = 1;
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            cur_ok = 0;
                            $display("FAIL unexpected_result: res_valid=1 q=%h at cycle %0d, required no result", res_q, cyc);
                        end else begin
                            cur    = sb.pop_front();
                            cur_ok = 1;
                            chk("res_latency_cycle", cyc, cur.at);
                            chk("res_q", res_q, cur.q);
                            chk("res_tag", {27'b0, res_tag}, {27'b0, cur.tag});
                            chk("res_src", {31'b0, res_src}, {31'b0, cur.src});
                        end
                    end else if (cur_ok) begin
                        chk("hold_q", res_q, cur.q);
                        chk("hold_tag", {27'b0, res_tag}, {27'b0, cur.tag});
                        chk("hold_src", {31'b0, res_src}, {31'b0, cur.src});
                    end
                end else begin
                    in_hold = 0;
                end
                chk("ready_exclusive", {31'b0, req0_ready & req1_ready}, 32'd0);
                chk("ready_while_busy", {31'b0, busy & (req0_ready | req1_ready)}, 32'd0);
                chk("fsqrt_without_en", {31'b0, sq_fsqrt & ~sq_en}, 32'd0);
            end
        end
    end

    task automatic push_exp(input logic [31:0] q, input logic [4:0] tag, input logic src, input int at);
        exp_t e;
        e.q = q; e.tag = tag; e.src = src; e.at = at;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_fsqrt", {31'b0, sq_fsqrt}, 32'd0);
        chk("rst_en", {31'b0, sq_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        chk("post_rst_res_q", res_q, 32'd0);
        chk("post_rst_res_tag", {27'b0, res_tag}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Present a request and wait for its grant; acc is the acceptance cycle.
    task automatic request(input bit v0, input bit v1,
                           input logic [23:0] d0, input logic [4:0] t0,
                           input logic [23:0] d1, input logic [4:0] t1,
                           input bit exp_src, input logic [31:0] exp_q,
                           input bit track, output int acc);
        bit got;
        got = 0;
        acc = -1;
        req0_valid = v0; req0_d = d0; req0_tag = t0;
        req1_valid = v1; req1_d = d1; req1_tag = t1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                got = 1;
                acc = cyc;
                chk("grant_src", {31'b0, req1_ready}, {31'b0, exp_src});
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: no ready in 100 cycles, required grant to %0d", exp_src);
        end else begin
            if (track) push_exp(exp_q, exp_src ? t1 : t0, exp_src, acc + LAT + 1);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0d after 200 cycles, required 0", busy);
        end
        @(posedge clk); #1;
    endtask

    // Ends on the falling edge of the first res_valid cycle.
    task automatic wait_res();
        bit ok;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (res_valid) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: res_valid=0 after 100 cycles, required 1");
        end
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_d = '0; req1_d = '0; req0_tag = '0; req1_tag = '0;
        flush = 1'b0;
        res_ready = 1'b1;
        do_reset();

        // Single request: root 1.0, tag 3 from requester 0.
        request(1, 0, 24'h800000, 5'd3, 24'h0, 5'd0, 0, 32'h8000_0000, 1, acc);
        wait_idle();

        // Ties from reset alternate 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            request(1, 1, 24'hC80000, 5'd5, 24'hA20000, 5'd9, i[0],
                    i[0] ? 32'h9000_0000 : 32'hA000_0000, 1, acc);
            wait_idle();
        end

        // Backpressure: held result with both requesters waiting.
        res_ready = 1'b0;
        request(0, 1, 24'h0, 5'd0, 24'hF20000, 5'd17, 1, 32'hB000_0000, 1, acc);
        req0_valid = 1'b1; req0_d = 24'h800000; req0_tag = 5'd3;
        req1_valid = 1'b1; req1_d = 24'hC80000; req1_tag = 5'd5;
        wait_res();
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("ready_in_release_cycle", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_release", {30'b0, req1_ready, req0_ready}, 32'd1);
        push_exp(32'h8000_0000, 5'd3, 1'b0, cyc + LAT + 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Flush in IDLE blocks acceptance.
        req0_valid = 1'b1; req0_d = 24'hA20000; req0_tag = 5'd7;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_no_accept", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        // Flush in WAIT at counter 10: no result, busy drops 25 cycles after ISSUE.
        request(1, 0, 24'h800000, 5'd4, 24'h0, 5'd0, 0, 32'h8000_0000, 0, acc);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        chk("flush_wait_busy_last", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("flush_wait_busy_drop", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        request(0, 1, 24'h0, 5'd0, 24'hA20000, 5'd9, 1, 32'h9000_0000, 1, acc);
        wait_idle();

        // Flush in HOLD, with and without res_ready.
        for (int k = 0; k < 2; k++) begin
            res_ready = (k == 0);
            request(1, 0, 24'hC80000, 5'(12 + k), 24'h0, 5'd0, 0, 32'hA000_0000, 1, acc);
            wait_res();
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            @(negedge clk);
            chk("flush_hold_res_valid", {31'b0, res_valid}, 32'd0);
            chk("flush_hold_busy", {31'b0, busy}, 32'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;

        // Reset at counter 12 abandons the operation.
        request(0, 1, 24'h0, 5'd0, 24'hF20000, 5'd20, 1, 32'hB000_0000, 0, acc);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_en", {31'b0, sq_en}, 32'd0);
        chk("midrst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("after_midrst_busy", {31'b0, busy}, 32'd0);
        chk("after_midrst_fsqrt", {31'b0, sq_fsqrt}, 32'd0);
        chk("after_midrst_res_q", res_q, 32'd0);
        chk("after_midrst_src", {31'b0, res_src}, 32'd0);
        @(posedge clk); #1;
        request(0, 1, 24'h0, 5'd0, 24'hF20000, 5'd21, 1, 32'hB000_0000, 1, acc);
        wait_idle();

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
